// File: rtl/if_trace_buffer_if.sv
// Bundle of capture-side, drain-side and status signals for the IF trace buffer.
// The master modport is the surrounding trace unit plus consumer; the slave is the buffer.
interface if_trace_buffer_if #(
  parameter int DATA_WIDTH        = 32,
  parameter int TRACE_BUFFER_SIZE = 128,
  parameter int DROP_COUNT_WIDTH  = 16
);
  localparam int OCC_WIDTH = $clog2(TRACE_BUFFER_SIZE) + 1;

  typedef logic [DATA_WIDTH-1:0] trace_output;

  logic                        trace_enable;
  logic                        if_data_ready;
  trace_output                 if_data_i;
  logic                        out_valid;
  logic                        out_ready;
  trace_output                 out_data;
  logic [OCC_WIDTH-1:0]        occupancy;
  logic                        empty;
  logic                        full;
  logic                        almost_full;
  logic                        overflow;
  logic [DROP_COUNT_WIDTH-1:0] drop_count;
  logic                        clear_status;

  modport master (
    output trace_enable, if_data_ready, if_data_i, out_ready, clear_status,
    input  out_valid, out_data, occupancy, empty, full, almost_full, overflow, drop_count
  );

  modport slave (
    input  trace_enable, if_data_ready, if_data_i, out_ready, clear_status,
    output out_valid, out_data, occupancy, empty, full, almost_full, overflow, drop_count
  );
endinterface

// File: rtl/if_trace_buffer.sv
// First-word-fall-through trace FIFO behind the IF tracker; the tracker cannot be
// stalled, so records arriving while full are dropped, counted and flagged.
module if_trace_buffer #(
  parameter int TRACE_BUFFER_SIZE     = 128,
  parameter int ALMOST_FULL_THRESHOLD = 120,
  parameter int DROP_COUNT_WIDTH      = 16,
  parameter int DATA_WIDTH            = 32
) (
  input  logic               clk,
  input  logic               rst,
  if_trace_buffer_if.slave   bus
);
  localparam int AW = $clog2(TRACE_BUFFER_SIZE);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] SIZE_C = PW'(TRACE_BUFFER_SIZE);
  localparam logic [PW-1:0] AF_C   = PW'(ALMOST_FULL_THRESHOLD);
  localparam logic [DROP_COUNT_WIDTH-1:0] DROP_MAX = '1;

  logic [DATA_WIDTH-1:0]       mem [TRACE_BUFFER_SIZE];

  logic [PW-1:0]               wrPtr_q, wrPtr_d;
  logic [PW-1:0]               rdPtr_q, rdPtr_d;
  logic [PW-1:0]               occ_q, occ_d;
  logic                        empty_q, empty_d;
  logic                        full_q, full_d;
  logic                        almostFull_q, almostFull_d;
  logic                        overflow_q, overflow_d;
  logic [DROP_COUNT_WIDTH-1:0] dropCount_q, dropCount_d;

  logic                        strobe;
  logic                        push;
  logic                        pop;
  logic                        drop;

  // A pop frees a slot in the same cycle, so a full buffer still accepts a record then.
  always_comb begin
    strobe = bus.if_data_ready && bus.trace_enable;
    pop    = !empty_q && bus.out_ready;
    push   = strobe && (!full_q || pop);
    drop   = strobe && full_q && !pop;
  end

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    occ_d   = occ_q;

    if (push) begin
      wrPtr_d = wrPtr_q + PW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   occ_d = occ_q + PW'(1);
      2'b01:   occ_d = occ_q - PW'(1);
      default: occ_d = occ_q;
    endcase

    empty_d      = (occ_d == '0);
    full_d       = (occ_d == SIZE_C);
    almostFull_d = (occ_d >= AF_C);
  end

  // Clear is applied first so that a drop in the same cycle is still recorded.
  always_comb begin
    overflow_d  = overflow_q;
    dropCount_d = dropCount_q;

    if (bus.clear_status) begin
      overflow_d  = 1'b0;
      dropCount_d = '0;
    end

    if (drop) begin
      overflow_d = 1'b1;
      if (dropCount_d != DROP_MAX) begin
        dropCount_d = dropCount_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      occ_q        <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      almostFull_q <= 1'b0;
      overflow_q   <= 1'b0;
      dropCount_q  <= '0;
    end else begin
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      occ_q        <= occ_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      almostFull_q <= almostFull_d;
      overflow_q   <= overflow_d;
      dropCount_q  <= dropCount_d;
    end
  end

  // Storage carries no reset; stale contents are hidden behind out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr_q[AW-1:0]] <= bus.if_data_i;
    end
  end

  assign bus.out_valid   = !empty_q;
  assign bus.out_data    = mem[rdPtr_q[AW-1:0]];
  assign bus.occupancy   = occ_q;
  assign bus.empty       = empty_q;
  assign bus.full        = full_q;
  assign bus.almost_full = almostFull_q;
  assign bus.overflow    = overflow_q;
  assign bus.drop_count  = dropCount_q;

endmodule

// File: tb/tb_if_trace_buffer.sv
// Directed bench for if_trace_buffer: a queue-based reference model compared every
// cycle, plus literal checkpoints that pin the model at key moments.
module tb_if_trace_buffer;
  localparam int SIZE     = 128;
  localparam int AF_TH    = 120;
  localparam int DCW      = 4;
  localparam int DROP_SAT = (1 << DCW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int vectors     = 0;
  int miscompares = 0;

  if_trace_buffer_if #(.DATA_WIDTH(32), .TRACE_BUFFER_SIZE(SIZE), .DROP_COUNT_WIDTH(DCW)) ifc ();

  if_trace_buffer #(
    .TRACE_BUFFER_SIZE(SIZE),
    .ALMOST_FULL_THRESHOLD(AF_TH),
    .DROP_COUNT_WIDTH(DCW),
    .DATA_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  always #5 clk = ~clk;

  logic [31:0] modelQ [$];
  logic        modelOvf;
  int          modelDrops;
  logic        mStrobe, mFull, mPop, mPush, mDrop;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rdy, input logic [31:0] data,
                               input logic outRdy, input logic clr);
    @(posedge clk);
    #1;
    ifc.trace_enable  = en;
    ifc.if_data_ready = rdy;
    ifc.if_data_i     = data;
    ifc.out_ready     = outRdy;
    ifc.clear_status  = clr;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_occupancy"},   32'(ifc.occupancy),   32'd0);
    checkOutput({tag, "_empty"},       32'(ifc.empty),       32'd1);
    checkOutput({tag, "_full"},        32'(ifc.full),        32'd0);
    checkOutput({tag, "_almost_full"}, 32'(ifc.almost_full), 32'd0);
    checkOutput({tag, "_out_valid"},   32'(ifc.out_valid),   32'd0);
    checkOutput({tag, "_overflow"},    32'(ifc.overflow),    32'd0);
    checkOutput({tag, "_drop_count"},  32'(ifc.drop_count),  32'd0);
  endtask

  // Reference model: the buffer is just an ordered queue with a capacity limit.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      modelQ.delete();
      modelOvf   = 1'b0;
      modelDrops = 0;
    end else begin
      mStrobe = ifc.trace_enable && ifc.if_data_ready;
      mFull   = (modelQ.size() == SIZE);
      mPop    = (modelQ.size() > 0) && ifc.out_ready;
      mPush   = mStrobe && (!mFull || mPop);
      mDrop   = mStrobe && mFull && !mPop;
      if (mPop) void'(modelQ.pop_front());
      if (mPush) modelQ.push_back(ifc.if_data_i);
      if (ifc.clear_status) begin
        modelOvf   = 1'b0;
        modelDrops = 0;
      end
      if (mDrop) begin
        modelOvf = 1'b1;
        if (modelDrops < DROP_SAT) modelDrops++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      checkOutput("cmp_out_valid",   32'(ifc.out_valid),   32'(modelQ.size() != 0));
      checkOutput("cmp_occupancy",   32'(ifc.occupancy),   32'(modelQ.size()));
      checkOutput("cmp_empty",       32'(ifc.empty),       32'(modelQ.size() == 0));
      checkOutput("cmp_full",        32'(ifc.full),        32'(modelQ.size() == SIZE));
      checkOutput("cmp_almost_full", 32'(ifc.almost_full), 32'(modelQ.size() >= AF_TH));
      checkOutput("cmp_overflow",    32'(ifc.overflow),    32'(modelOvf));
      checkOutput("cmp_drop_count",  32'(ifc.drop_count),  32'(modelDrops));
      if (modelQ.size() != 0) begin
        checkOutput("cmp_out_data", ifc.out_data, modelQ[0]);
      end
    end
  end

  function automatic logic [31:0] rec(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  initial begin
    int sent;
    ifc.trace_enable  = 1'b0;
    ifc.if_data_ready = 1'b0;
    ifc.if_data_i     = 32'h0;
    ifc.out_ready     = 1'b0;
    ifc.clear_status  = 1'b0;

    #1 rst = 1'b0;
    #11;
    checkResetValues("reset");
    #10 rst = 1'b1;

    // Latency: A then B with the consumer stalled.
    applyStimulus(1'b1, 1'b1, rec(0), 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, rec(1), 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("lat_valid_after_A", 32'(ifc.out_valid), 32'd1);
    checkOutput("lat_data_A",        ifc.out_data,       32'hC0DE_0000);
    checkOutput("lat_occ_1",         32'(ifc.occupancy), 32'd1);

    // Fill to 131 records total; the last three must be dropped.
    for (int i = 2; i <= 130; i++) begin
      applyStimulus(1'b1, 1'b1, rec(i), 1'b0, 1'b0);
      @(negedge clk);
      if (i == 2) begin
        checkOutput("stall_occ_2",  32'(ifc.occupancy), 32'd2);
        checkOutput("stall_data_A", ifc.out_data,       32'hC0DE_0000);
      end
      if (i == 119) checkOutput("af_at_119",   32'(ifc.almost_full), 32'd0);
      if (i == 120) checkOutput("af_at_120",   32'(ifc.almost_full), 32'd1);
      if (i == 127) checkOutput("full_at_127", 32'(ifc.full),        32'd0);
      if (i == 128) checkOutput("full_at_128", 32'(ifc.full),        32'd1);
    end
    idle();
    @(negedge clk);
    checkOutput("fill_occ",      32'(ifc.occupancy),  32'd128);
    checkOutput("fill_overflow", 32'(ifc.overflow),   32'd1);
    checkOutput("fill_drops",    32'(ifc.drop_count), 32'd3);

    // Pop and push together while full.
    applyStimulus(1'b1, 1'b1, 32'hF00D_0200, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    checkOutput("fullpp_occ",   32'(ifc.occupancy),  32'd128);
    checkOutput("fullpp_drops", 32'(ifc.drop_count), 32'd3);
    checkOutput("fullpp_head",  ifc.out_data,        32'hC0DE_0001);

    for (int i = 0; i < 128; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    checkOutput("drain_empty", 32'(ifc.empty), 32'd1);

    // Pop and push together with a single entry stored.
    applyStimulus(1'b1, 1'b1, 32'h1111_0001, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h2222_0002, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    checkOutput("onepp_occ",  32'(ifc.occupancy), 32'd1);
    checkOutput("onepp_head", ifc.out_data,       32'h2222_0002);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    idle();

    // Wrap-around stream with a randomly stalling consumer.
    sent = 0;
    for (int c = 0; c < 6000 && sent < 1000; c++) begin
      if ($urandom_range(2) == 0) begin
        applyStimulus(1'b1, 1'b1, 32'h5000_0000 + 32'(sent), 1'($urandom_range(1)), 1'b0);
        sent++;
      end else begin
        applyStimulus(1'b0, 1'b0, 32'h0, 1'($urandom_range(1)), 1'b0);
      end
    end
    for (int c = 0; c < 200; c++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    checkOutput("wrap_sent",  32'(sent),            32'd1000);
    checkOutput("wrap_empty", 32'(ifc.empty),       32'd1);
    checkOutput("wrap_drops", 32'(ifc.drop_count),  32'd3);

    // Clear, then strobes with capture disabled.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    checkOutput("clr_overflow", 32'(ifc.overflow),   32'd0);
    checkOutput("clr_drops",    32'(ifc.drop_count), 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 32'hDEAD_0000 + 32'(i), 1'b0, 1'b0);
    idle();
    @(negedge clk);
    checkOutput("dis_occ",   32'(ifc.occupancy),  32'd0);
    checkOutput("dis_drops", 32'(ifc.drop_count), 32'd0);

    // Refill, drop coincident with clear, then saturate the counter.
    for (int i = 0; i < 128; i++) applyStimulus(1'b1, 1'b1, 32'h7000_0000 + 32'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'hBAD0_0000, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    checkOutput("clrdrop_drops",    32'(ifc.drop_count), 32'd1);
    checkOutput("clrdrop_overflow", 32'(ifc.overflow),   32'd1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 32'hBAD1_0000 + 32'(i), 1'b0, 1'b0);
    idle();
    @(negedge clk);
    checkOutput("sat_drops", 32'(ifc.drop_count), 32'd15);
    checkOutput("sat_head",  ifc.out_data,        32'h7000_0000);

    // Mid-operation reset with 50 entries stored.
    for (int i = 0; i < 78; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    checkOutput("pre_rst_occ", 32'(ifc.occupancy), 32'd50);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checkResetValues("midrst");
    @(posedge clk);
    #3 rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'hABCD_0001, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    checkOutput("post_rst_valid", 32'(ifc.out_valid), 32'd1);
    checkOutput("post_rst_head",  ifc.out_data,       32'hABCD_0001);
    checkOutput("post_rst_occ",   32'(ifc.occupancy), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_trace_buffer.md
# if_trace_buffer

First-word-fall-through FIFO that sits directly downstream of the trace unit's IF tracker. It captures every `trace_output` record the tracker strobes out and holds it until a drain-side consumer accepts it over a valid/ready handshake. The tracker cannot be back-pressured, so when the buffer is full, records are dropped, counted, and flagged. The block decouples bursty instruction-fetch tracing from a slower readout path.

## Interface
- `TRACE_BUFFER_SIZE`, 128: entry count; power of two, ≥ 2.
- `ALMOST_FULL_THRESHOLD`, 120: `almost_full` asserts when occupancy ≥ this value; range 1..`TRACE_BUFFER_SIZE`.
- `DROP_COUNT_WIDTH`, 16: width of the dropped-record counter.
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `trace_enable`, in, 1: capture enable.
- `if_data_ready`, in, 1: one-cycle record strobe from the trace unit.
- `if_data_i`, in, `trace_output`: record; valid only while `if_data_ready` is high.
- `out_valid`, out, 1: head entry available.
- `out_ready`, in, 1: consumer accepts the head entry.
- `out_data`, out, `trace_output`: head entry.
- `occupancy`, out, $clog2(`TRACE_BUFFER_SIZE`)+1: stored entry count.
- `empty`, `full`, `almost_full`, out, 1 each: status flags.
- `overflow`, out, 1: sticky; set when any record has been dropped.
- `drop_count`, out, `DROP_COUNT_WIDTH`: saturating count of dropped records.
- `clear_status`, in, 1: synchronous clear of `overflow` and `drop_count`.

## Operation
- Storage is a circular array of `TRACE_BUFFER_SIZE` entries.
- Read and write pointers are $clog2(SIZE)+1 bits wide. The MSB distinguishes full from empty; the pointers wrap naturally.
- **Push:** occurs when `if_data_ready` && `trace_enable` && (!`full` || pop). A push writes `if_data_i` at `wr_ptr`, then `wr_ptr`++.
- **Pop:** occurs when `out_valid` && `out_ready`. A pop increments `rd_ptr`.
- **Drop:** occurs when `if_data_ready` && `trace_enable` && `full` && no pop.
  - The record is discarded and `overflow` is set to 1.
  - `drop_count`++ unless it is already all-ones (saturates and stays).
- **Capture disabled:** `if_data_ready` while `trace_enable` = 0 is ignored. It is neither stored nor counted as a drop.
- **Occupancy update:**
  - push-only: +1.
  - pop-only: −1.
  - push and pop together: unchanged, including when full or when holding one entry.
- **Flags:**
  - `empty` = (occupancy == 0).
  - `full` = (occupancy == SIZE).
  - `almost_full` = (occupancy ≥ `ALMOST_FULL_THRESHOLD`).
  - `out_valid` = !`empty`.
  - `out_data` = entry at `rd_ptr`.
- **`clear_status`:** the next cycle sees `overflow` = 0 and `drop_count` = 0. If a drop occurs in the same cycle, the drop wins: `overflow` = 1, `drop_count` = 1.
- **No bypass:** a push into an empty buffer is not visible on `out_data` in the same cycle.
- **Reset (`rst` low):** asynchronous and immediate, including mid-operation.
  - Pointers → 0, `occupancy` 0, `empty` 1, `full` 0, `almost_full` 0, `out_valid` 0, `overflow` 0, `drop_count` 0.
  - `out_data` is don't-care while `out_valid` = 0.
  - Stored contents are discarded; the storage array itself needs no reset.
  - Operation resumes on the first rising edge after `rst` deasserts.

## Timing
- Write-to-read latency: a record pushed at edge N has `out_valid` = 1 and `out_data` = that record after edge N, i.e. during cycle N+1.
- `out_data` and `out_valid` hold stable while `out_valid` && !`out_ready`.
- The consumer may hold `out_ready` high continuously. With one push per cycle, the buffer then sustains one pop per cycle and occupancy stays constant.
- `occupancy`, all flags, `overflow`, and `drop_count` are registered and update one edge after the causing event.
- `out_ready` while `out_valid` = 0 has no effect.
- There is no combinational path from `out_ready` or `if_data_ready` to any output except through the storage read mux.

## Test plan
- **Reset and latency:** assert `rst` low, release, then push records A, B on consecutive cycles with `out_ready` = 0.
  - Reset values are as listed above.
  - `out_valid` rises one cycle after A's push, with `out_data` = A.
  - `occupancy` = 2, and `out_data` holds A while stalled.
- **Fill and overflow:** with SIZE = 128 and `out_ready` = 0, push 131 records.
  - `almost_full` rises when occupancy reaches 120; `full` rises at 128.
  - `overflow` = 1 and `drop_count` = 3.
  - Draining returns exactly records 0–127 in order.
- **Simultaneous push and pop:**
  - When full, pop plus push leaves `occupancy` at 128 with no drop counted.
  - When holding one entry, pop plus push leaves `occupancy` at 1, and the new record is the head next cycle.
- **Wrap-around:** stream 1000 records with random `out_ready` at about 50%, never reaching full.
  - Output order matches input order exactly; no drops; `empty` = 1 at the end.
- **Enable and clear:**
  - With `trace_enable` = 0, 5 strobes leave occupancy 0 and `drop_count` 0.
  - With the buffer full, pulse `clear_status` in the same cycle as a drop: `drop_count` = 1 and `overflow` = 1.
  - Drive `drop_count` to all-ones (DROP_COUNT_WIDTH = 4, 20 drops): it saturates at 15.
- **Mid-operation reset:** assert `rst` asynchronously, between clock edges, with 50 entries stored.
  - All outputs take their reset values immediately.
  - After release, the first new push appears at the head one cycle later.
